// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB receive bit controller.
// Pure declarations: no latency and no flow control.
package usb_rx_pkg;

    localparam int USB_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ERR
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_STUFF,
        ERR_EOP,
        ERR_ALIGN
    } rx_err_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Tracks consecutive decoded 1s and classifies each DATA bit as payload, dropped stuff bit or stuff error.
// Combinational verdict on the same clk as bit_vld; no backpressure, one bit per bit_vld.
module usb_bit_unstuffer #(
    parameter int MAX_ONES = 6
) (
    input  logic clk,
    input  logic nRST,
    input  logic load,
    input  logic bit_vld,
    input  logic bit_in,
    output logic data_vld,
    output logic stuff_err
);

    logic [2:0] ones_cnt;
    logic       is_stuff;

    assign is_stuff  = (ones_cnt == 3'(MAX_ONES));
    assign data_vld  = bit_vld & ~is_stuff;
    assign stuff_err = bit_vld & is_stuff & bit_in;

    // The SYNC-terminating 1 already counts toward the run, hence load to 1.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ones_cnt <= 3'd0;
        end else if (load) begin
            ones_cnt <= 3'd1;
        end else if (bit_vld) begin
            if (is_stuff || !bit_in) begin
                ones_cnt <= 3'd0;
            end else begin
                ones_cnt <= ones_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_rx_bit_controller.sv
// Sequences the NRZI decoder: SYNC hunt, unstuffing, LSB-first byte assembly, EOP and error flags.
// rx_byte_valid/eop land 1 clk after the decoded bit's dec_strobe; no backpressure, one bit per bit_strobe.
module usb_rx_bit_controller
    import usb_rx_pkg::*;
#(
    parameter int SYNC_ZEROS   = 6,
    parameter int MAX_ONES     = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       bit_strobe,
    input  logic       line_j,
    input  logic       line_se0,
    input  logic       decoded_bit,
    output logic       start_decoding,
    output logic       rx_active,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       eop,
    output logic [1:0] rx_err
);

    rx_state_t                 state;
    rx_err_t                   err_q;
    logic                      dec_strobe;
    logic                      j_lat;
    logic                      se0_lat;
    logic [2:0]                zero_cnt;
    logic [2:0]                bit_cnt;
    logic [1:0]                se0_cnt;
    logic [2:0]                j_cnt;
    logic [USB_BYTE_W-1:0]     byte_sr;
    logic [USB_BYTE_W-1:0]     byte_nxt;
    logic                      sync_done;
    logic                      us_bit_vld;
    logic                      us_data_vld;
    logic                      us_stuff_err;

    assign rx_err   = err_q;
    assign byte_nxt = {decoded_bit, byte_sr[USB_BYTE_W-1:1]};

    assign sync_done  = dec_strobe && (state == SYNC) && !se0_lat && decoded_bit
                        && (zero_cnt >= 3'(SYNC_ZEROS));
    assign us_bit_vld = dec_strobe && (state == DATA) && !se0_lat;

    usb_bit_unstuffer #(
        .MAX_ONES (MAX_ONES)
    ) u_unstuffer (
        .clk       (clk),
        .nRST      (nRST),
        .load      (sync_done),
        .bit_vld   (us_bit_vld),
        .bit_in    (decoded_bit),
        .data_vld  (us_data_vld),
        .stuff_err (us_stuff_err)
    );

    // Line state is latched with bit_strobe so every post-IDLE decision sees the
    // line condition and the decoded bit of the same bit time on dec_strobe.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            err_q          <= ERR_NONE;
            dec_strobe     <= 1'b0;
            j_lat          <= 1'b0;
            se0_lat        <= 1'b0;
            zero_cnt       <= 3'd0;
            bit_cnt        <= 3'd0;
            se0_cnt        <= 2'd0;
            j_cnt          <= 3'd0;
            byte_sr        <= '0;
            start_decoding <= 1'b0;
            rx_active      <= 1'b0;
            rx_byte        <= '0;
            rx_byte_valid  <= 1'b0;
            eop            <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            eop           <= 1'b0;
            dec_strobe    <= bit_strobe;
            if (bit_strobe) begin
                j_lat   <= line_j;
                se0_lat <= line_se0;
            end

            case (state)
                IDLE: begin
                    start_decoding <= 1'b0;
                    if (bit_strobe && !line_j && !line_se0) begin
                        start_decoding <= 1'b1;
                        zero_cnt       <= 3'd0;
                        state          <= SYNC;
                    end
                end

                SYNC: begin
                    if (dec_strobe) begin
                        if (se0_lat) begin
                            start_decoding <= 1'b0;
                            state          <= IDLE;
                        end else if (!decoded_bit) begin
                            zero_cnt <= sat_inc3(zero_cnt);
                        end else if (sync_done) begin
                            rx_active <= 1'b1;
                            err_q     <= ERR_NONE;
                            bit_cnt   <= 3'd0;
                            state     <= DATA;
                        end else begin
                            zero_cnt <= 3'd0;
                        end
                    end
                end

                DATA: begin
                    if (dec_strobe) begin
                        if (se0_lat) begin
                            se0_cnt <= 2'd1;
                            state   <= EOP;
                        end else if (us_stuff_err) begin
                            err_q          <= ERR_STUFF;
                            rx_active      <= 1'b0;
                            start_decoding <= 1'b0;
                            se0_cnt        <= 2'd0;
                            j_cnt          <= 3'd0;
                            state          <= ERR;
                        end else if (us_data_vld) begin
                            byte_sr <= byte_nxt;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(USB_BYTE_W - 1)) begin
                                rx_byte       <= byte_nxt;
                                rx_byte_valid <= 1'b1;
                            end
                        end
                    end
                end

                EOP: begin
                    if (dec_strobe) begin
                        if (se0_lat) begin
                            se0_cnt <= sat_inc2(se0_cnt);
                        end else if (j_lat && (se0_cnt >= 2'(EOP_SE0_BITS))) begin
                            eop            <= 1'b1;
                            rx_active      <= 1'b0;
                            start_decoding <= 1'b0;
                            state          <= IDLE;
                            if (bit_cnt != 3'd0) begin
                                err_q <= ERR_ALIGN;
                            end
                        end else begin
                            err_q          <= ERR_EOP;
                            rx_active      <= 1'b0;
                            start_decoding <= 1'b0;
                            se0_cnt        <= 2'd0;
                            j_cnt          <= 3'd0;
                            state          <= ERR;
                        end
                    end
                end

                ERR: begin
                    start_decoding <= 1'b0;
                    if (dec_strobe) begin
                        if (se0_lat) begin
                            se0_cnt <= sat_inc2(se0_cnt);
                            j_cnt   <= 3'd0;
                        end else if (j_lat) begin
                            se0_cnt <= 2'd0;
                            if ((se0_cnt >= 2'(EOP_SE0_BITS)) || (j_cnt == 3'd7)) begin
                                state <= IDLE;
                            end else begin
                                j_cnt <= j_cnt + 3'd1;
                            end
                        end else begin
                            se0_cnt <= 2'd0;
                            j_cnt   <= 3'd0;
                        end
                    end
                end

                default: begin
                    start_decoding <= 1'b0;
                    rx_active      <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
